write_back: RTL
===============

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter ADDRESS_STEP, default 4, byte offset of the upper word in a two-word memory store.
REQ-002 Port clock  input  1  sole clock; all state on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port in_valid  input  1  execute stage presents an instruction.
REQ-005 Port in_hold  output  1  write stage cannot accept; execute holds its outputs.
REQ-006 Port in_pc  input  32  instruction PC.
REQ-007 Port in_target_register  input  5  destination register index.
REQ-008 Port in_address_register  input  5  base register index for a store.
REQ-009 Port in_is_writing_memory  input  1  instruction is a store.
REQ-010 Port in_flags  input  4  {carry, negative, overflow, zero}.
REQ-011 Port in_target_value, in_upper_value, in_adjustment_value  input  32 each  result low word, result high word, store offset.
REQ-012 Port in_has_upper_value  input  1  upper word valid.
REQ-013 Port in_has_flushed  input  1  instruction squashed; retire with no side effects.
REQ-014 Port base_index  output  5 / base_value  input  32  combinational register-file read of the store base.
REQ-015 Port reg_we, reg2_we  output  1 each / reg_index, reg2_index  output  5 / reg_value, reg2_value  output  32  two register-file write ports.
REQ-016 Port flags_we  output  1 / flags_value  output  4  flags-register update.
REQ-017 Port mem_write  output  1 / mem_address, mem_data  output  32 / mem_wait  input  1  memory store port.
REQ-018 Port retired_count  output  32  count of committed instructions.

Function
REQ-019 Acceptance occurs on a rising edge with in_valid=1 and in_hold=0; states IDLE, STORE_LO, STORE_HI.
REQ-020 in_hold = (state != IDLE), combinational.
REQ-021 Non-store accept, not flushed: next cycle reg_we=1, reg_index=in_target_register, reg_value=in_target_value, flags_we=1, flags_value=in_flags, for exactly one cycle.
REQ-022 Same case with in_has_upper_value=1: reg2_we=1, reg2_index=(in_target_register+1) mod 32, reg2_value=in_upper_value, same cycle.
REQ-023 Any register write whose index is 0 SHALL be suppressed (we forced 0); flags still written.
REQ-024 Store accept, not flushed: go STORE_LO; mem_write=1, mem_address=base_value+in_adjustment_value (mod 2^32, sampled at accept), mem_data=in_target_value; flags_we pulse next cycle; no reg writes.
REQ-025 STORE_LO: mem_address, mem_data, mem_write stable while mem_wait=1; on edge with mem_wait=0, go STORE_HI if upper valid, else IDLE with mem_write=0.
REQ-026 STORE_HI: mem_address=low address+ADDRESS_STEP (wraps mod 2^32), mem_data=in_upper_value; same mem_wait rule, then IDLE.
REQ-027 Flushed accept: no reg, flags or memory writes; state stays IDLE; retired_count unchanged.
REQ-028 retired_count increments by 1 on each non-flushed non-store accept, and on store completion (final mem_wait=0 edge); wraps 0xFFFFFFFF->0.
REQ-029 Back-to-back non-store instructions SHALL be accepted every cycle (throughput 1/cycle); stores block for 1+wait cycles per word.
REQ-030 in_valid=0 in IDLE: all write enables 0 next cycle.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, in_hold=0, reg_we=reg2_we=flags_we=mem_write=0, retired_count=0, data outputs 0.
REQ-032 reset asserted mid-store abandons the store; no further mem_write after release until a new accept.

Verification
REQ-033 Accept target r5, value 0x12345678, flags 4'b0001 -> next cycle reg_we=1, index 5, value 0x12345678, flags_we=1, count=1.
REQ-034 Accept target r31, upper 0xDEADBEEF -> reg2_index=0 suppressed (reg2_we=0), reg_we=1 for r31.
REQ-035 Store base 0x1000, offset 0x10, data 0xAA, upper 0xBB, mem_wait high 2 cycles each word -> 0x1010/0xAA then 0x1014/0xBB, in_hold high throughout, count+1 at end.
REQ-036 Store base 0xFFFFFFFC, offset 0, upper valid -> second address 0x00000000.
REQ-037 Flushed instruction target r3 -> no enables, count unchanged; reset during STORE_LO with mem_wait=1 -> mem_write=0 immediately, count=0.

Source files
------------

// File: rtl/write_back.sv
// Write-back stage: commits execute results to the register file and flags,
// and performs one- or two-word memory stores under a mem_wait handshake.
module write_back #(
  parameter int unsigned ADDRESS_STEP = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_hold,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_target_register,
  input  logic [4:0]  in_address_register,
  input  logic        in_is_writing_memory,
  input  logic [3:0]  in_flags,
  input  logic [31:0] in_target_value,
  input  logic [31:0] in_upper_value,
  input  logic [31:0] in_adjustment_value,
  input  logic        in_has_upper_value,
  input  logic        in_has_flushed,

  output logic [4:0]  base_index,
  input  logic [31:0] base_value,

  output logic        reg_we,
  output logic [4:0]  reg_index,
  output logic [31:0] reg_value,
  output logic        reg2_we,
  output logic [4:0]  reg2_index,
  output logic [31:0] reg2_value,

  output logic        flags_we,
  output logic [3:0]  flags_value,

  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  input  logic        mem_wait,

  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STORE_LO = 2'd1,
    STORE_HI = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        commit;
  logic        store_done;
  logic        lo_done;
  logic        upper_pending;
  logic [31:0] upper_data;
  logic [4:0]  upper_index;

  // The PC travels with the instruction for debug only; nothing here consumes it.
  logic unused_pc;
  assign unused_pc = ^in_pc;

  assign in_hold     = (state != IDLE);
  assign mem_write   = (state != IDLE);
  assign base_index  = in_address_register;
  assign accept      = in_valid && (state == IDLE);
  assign commit      = accept && !in_has_flushed;
  assign upper_index = in_target_register + 5'd1;
  assign lo_done     = (state == STORE_LO) && !mem_wait;
  assign store_done  = (lo_done && !upper_pending) ||
                       ((state == STORE_HI) && !mem_wait);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the combinational block below uses blocking assignments.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:     if (commit && in_is_writing_memory) next_state = STORE_LO;
      STORE_LO: if (!mem_wait) next_state = upper_pending ? STORE_HI : IDLE;
      STORE_HI: if (!mem_wait) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Register-file and flags ports: enables pulse for the single cycle after accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_we      <= 1'b0;
      reg_index   <= '0;
      reg_value   <= '0;
      reg2_we     <= 1'b0;
      reg2_index  <= '0;
      reg2_value  <= '0;
      flags_we    <= 1'b0;
      flags_value <= '0;
    end else begin
      reg_we   <= 1'b0;
      reg2_we  <= 1'b0;
      flags_we <= 1'b0;
      if (commit) begin
        flags_we    <= 1'b1;
        flags_value <= in_flags;
        if (!in_is_writing_memory) begin
          // Writes to r0 are dropped; the flags update still happens.
          reg_we     <= (in_target_register != 5'd0);
          reg_index  <= in_target_register;
          reg_value  <= in_target_value;
          reg2_we    <= in_has_upper_value && (upper_index != 5'd0);
          reg2_index <= upper_index;
          reg2_value <= in_upper_value;
        end
      end
    end
  end

  // Store datapath: address and data are captured at accept and held across waits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address   <= '0;
      mem_data      <= '0;
      upper_data    <= '0;
      upper_pending <= 1'b0;
    end else if (commit && in_is_writing_memory) begin
      mem_address   <= base_value + in_adjustment_value;
      mem_data      <= in_target_value;
      upper_data    <= in_upper_value;
      upper_pending <= in_has_upper_value;
    end else if (lo_done && upper_pending) begin
      mem_address   <= mem_address + 32'(ADDRESS_STEP);
      mem_data      <= upper_data;
      upper_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_count <= '0;
    end else if ((commit && !in_is_writing_memory) || store_done) begin
      retired_count <= retired_count + 32'd1;
    end
  end

endmodule
